// File: rtl/dpus_writeback.sv
// DPUS writeback stage: funnels result/auxiliar into a single RF write port and keeps NZCV flags.
// Optional macro WB_LONG_WRITE_EN enables the second (auxiliar -> rd_hi) write of long operations.
module dpus_writeback #(
   parameter int RF_AW = 4,
   parameter int DW    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [DW-1:0]    result,
   input  logic [DW-1:0]    auxiliar,
   input  logic [3:0]       flags,
   input  logic [RF_AW-1:0] rd,
   input  logic [RF_AW-1:0] rd_hi,
   input  logic             reg_write,
   input  logic             long_write,
   input  logic             flag_write,
   output logic             rf_we,
   output logic [RF_AW-1:0] rf_wa,
   output logic [DW-1:0]    rf_wd,
   output logic [3:0]       flags_q,
   output logic             busy
);

`ifdef WB_LONG_WRITE_EN
   typedef enum logic [1:0] {IDLE, WR_RES, WR_AUX} wbState_t;
`else
   typedef enum logic [1:0] {IDLE, WR_RES} wbState_t;
`endif

   wbState_t state;
   logic     accept;

   assign accept = in_valid & in_ready;
   assign busy   = (state != IDLE);

`ifdef WB_LONG_WRITE_EN
   logic             longH;
   logic [RF_AW-1:0] rdHiH;
   logic [DW-1:0]    auxH;

   // The aux write owns the port next cycle, so nothing new may be taken now.
   assign in_ready = !(state == WR_RES && longH);
`else
   logic unusedLong;

   assign unusedLong = ^{long_write, auxiliar, rd_hi};
   assign in_ready   = 1'b1;
`endif

   // rf_wa/rf_wd double as the held rd/result; the aux path keeps its own copies.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         rf_we   <= 1'b0;
         rf_wa   <= '0;
         rf_wd   <= '0;
         flags_q <= 4'b0000;
`ifdef WB_LONG_WRITE_EN
         longH   <= 1'b0;
         rdHiH   <= '0;
         auxH    <= '0;
`endif
      end else begin
         if (accept && flag_write)
            flags_q <= flags;
`ifdef WB_LONG_WRITE_EN
         if (accept) begin
            longH <= long_write & reg_write;
            rdHiH <= rd_hi;
            auxH  <= auxiliar;
         end
         if (state == WR_RES && longH) begin
            state <= WR_AUX;
            rf_we <= 1'b1;
            rf_wa <= rdHiH;
            rf_wd <= auxH;
         end else
`endif
         if (accept && reg_write) begin
            state <= WR_RES;
            rf_we <= 1'b1;
            rf_wa <= rd;
            rf_wd <= result;
         end else begin
            state <= IDLE;
            rf_we <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dpus_writeback.sv
// Directed self-checking bench for dpus_writeback; long-write tests follow WB_LONG_WRITE_EN.
module tb_dpus_writeback;
   localparam int RF_AW = 4;
   localparam int DW    = 32;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [DW-1:0]    result;
   logic [DW-1:0]    auxiliar;
   logic [3:0]       flags;
   logic [RF_AW-1:0] rd;
   logic [RF_AW-1:0] rd_hi;
   logic             reg_write;
   logic             long_write;
   logic             flag_write;
   logic             rf_we;
   logic [RF_AW-1:0] rf_wa;
   logic [DW-1:0]    rf_wd;
   logic [3:0]       flags_q;
   logic             busy;

   int nCmp = 0;
   int nErr = 0;
   logic [RF_AW+DW:0] wrExp;

   dpus_writeback #(.RF_AW(RF_AW), .DW(DW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .result(result), .auxiliar(auxiliar), .flags(flags), .rd(rd), .rd_hi(rd_hi),
      .reg_write(reg_write), .long_write(long_write), .flag_write(flag_write),
      .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .flags_q(flags_q), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [DW-1:0] res, input logic [DW-1:0] aux,
                        input logic [3:0] fl, input logic [RF_AW-1:0] d, input logic [RF_AW-1:0] dHi,
                        input logic rw, input logic lw, input logic fw);
      in_valid = v; result = res; auxiliar = aux; flags = fl;
      rd = d; rd_hi = dHi; reg_write = rw; long_write = lw; flag_write = fw;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      drive(1'b0, '0, '0, 4'h0, '0, '0, 1'b0, 1'b0, 1'b0);
      #12;
      wrExp = '0;
      nCmp++; if ({rf_we, rf_wa, rf_wd} !== wrExp) begin nErr++; $display("FAIL reset_wr got=%h exp=%h", {rf_we, rf_wa, rf_wd}, wrExp); end
      nCmp++; if (flags_q !== 4'b0000) begin nErr++; $display("FAIL reset_flags got=%b exp=0000", flags_q); end
      nCmp++; if (busy !== 1'b0) begin nErr++; $display("FAIL reset_busy got=%b exp=0", busy); end
      reset = 1'b1;
      step();
      nCmp++; if (in_ready !== 1'b1) begin nErr++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
      nCmp++; if (rf_we !== 1'b0) begin nErr++; $display("FAIL reset_idle_we got=%b exp=0", rf_we); end
   endtask

   task automatic test_single;
      drive(1'b1, 32'h5, 32'h0, 4'b0100, 4'd3, 4'd0, 1'b1, 1'b0, 1'b1);
      step();
      in_valid = 1'b0;
      wrExp = {1'b1, 4'd3, 32'h5};
      nCmp++; if ({rf_we, rf_wa, rf_wd} !== wrExp) begin nErr++; $display("FAIL single_wr got=%h exp=%h", {rf_we, rf_wa, rf_wd}, wrExp); end
      nCmp++; if (flags_q !== 4'b0100) begin nErr++; $display("FAIL single_flags got=%b exp=0100", flags_q); end
      nCmp++; if (busy !== 1'b1) begin nErr++; $display("FAIL single_busy got=%b exp=1", busy); end
      step();
      wrExp = {1'b0, 4'd3, 32'h5};
      nCmp++; if ({rf_we, rf_wa, rf_wd} !== wrExp) begin nErr++; $display("FAIL single_hold got=%h exp=%h", {rf_we, rf_wa, rf_wd}, wrExp); end
      nCmp++; if (busy !== 1'b0) begin nErr++; $display("FAIL single_idle got=%b exp=0", busy); end
   endtask

   task automatic test_flags_only;
      drive(1'b1, 32'hAA, 32'h0, 4'b1001, 4'd9, 4'd0, 1'b0, 1'b0, 1'b1);
      step();
      in_valid = 1'b0;
      wrExp = {1'b0, 4'd3, 32'h5};
      nCmp++; if (flags_q !== 4'b1001) begin nErr++; $display("FAIL flagsonly_flags got=%b exp=1001", flags_q); end
      nCmp++; if ({rf_we, rf_wa, rf_wd} !== wrExp) begin nErr++; $display("FAIL flagsonly_wr got=%h exp=%h", {rf_we, rf_wa, rf_wd}, wrExp); end
      nCmp++; if (busy !== 1'b0) begin nErr++; $display("FAIL flagsonly_busy got=%b exp=0", busy); end
   endtask

   task automatic test_back_to_back;
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, 32'h10 + 32'(i), 32'h0, 4'b0000, 4'(i), 4'd0, 1'b1, 1'b0, 1'b0);
         nCmp++; if (in_ready !== 1'b1) begin nErr++; $display("FAIL b2b_ready%0d got=%b exp=1", i, in_ready); end
         step();
         wrExp = {1'b1, 4'(i), 32'h10 + 32'(i)};
         nCmp++; if ({rf_we, rf_wa, rf_wd} !== wrExp) begin nErr++; $display("FAIL b2b_wr%0d got=%h exp=%h", i, {rf_we, rf_wa, rf_wd}, wrExp); end
      end
      in_valid = 1'b0;
      step();
      nCmp++; if (rf_we !== 1'b0) begin nErr++; $display("FAIL b2b_end_we got=%b exp=0", rf_we); end
      nCmp++; if (flags_q !== 4'b1001) begin nErr++; $display("FAIL b2b_flags got=%b exp=1001", flags_q); end
   endtask

`ifdef WB_LONG_WRITE_EN
   task automatic test_long;
      drive(1'b1, 32'h1, 32'hFFFF_FFFF, 4'b0000, 4'd2, 4'd7, 1'b1, 1'b1, 1'b0);
      nCmp++; if (in_ready !== 1'b1) begin nErr++; $display("FAIL long_ready0 got=%b exp=1", in_ready); end
      step();
      // next op waits while the aux write is pending
      drive(1'b1, 32'h55, 32'h0, 4'b0000, 4'd5, 4'd0, 1'b1, 1'b0, 1'b0);
      wrExp = {1'b1, 4'd2, 32'h1};
      nCmp++; if ({rf_we, rf_wa, rf_wd} !== wrExp) begin nErr++; $display("FAIL long_res got=%h exp=%h", {rf_we, rf_wa, rf_wd}, wrExp); end
      nCmp++; if (in_ready !== 1'b0) begin nErr++; $display("FAIL long_ready1 got=%b exp=0", in_ready); end
      step();
      wrExp = {1'b1, 4'd7, 32'hFFFF_FFFF};
      nCmp++; if ({rf_we, rf_wa, rf_wd} !== wrExp) begin nErr++; $display("FAIL long_aux got=%h exp=%h", {rf_we, rf_wa, rf_wd}, wrExp); end
      nCmp++; if (in_ready !== 1'b1) begin nErr++; $display("FAIL long_ready2 got=%b exp=1", in_ready); end
      step();
      in_valid = 1'b0;
      wrExp = {1'b1, 4'd5, 32'h55};
      nCmp++; if ({rf_we, rf_wa, rf_wd} !== wrExp) begin nErr++; $display("FAIL long_stalled got=%h exp=%h", {rf_we, rf_wa, rf_wd}, wrExp); end
      step();
      nCmp++; if (rf_we !== 1'b0) begin nErr++; $display("FAIL long_end_we got=%b exp=0", rf_we); end
      // rd_hi == rd: aux must land last
      drive(1'b1, 32'hA, 32'hB, 4'b0000, 4'd4, 4'd4, 1'b1, 1'b1, 1'b0);
      step();
      in_valid = 1'b0;
      wrExp = {1'b1, 4'd4, 32'hA};
      nCmp++; if ({rf_we, rf_wa, rf_wd} !== wrExp) begin nErr++; $display("FAIL same_res got=%h exp=%h", {rf_we, rf_wa, rf_wd}, wrExp); end
      step();
      wrExp = {1'b1, 4'd4, 32'hB};
      nCmp++; if ({rf_we, rf_wa, rf_wd} !== wrExp) begin nErr++; $display("FAIL same_aux got=%h exp=%h", {rf_we, rf_wa, rf_wd}, wrExp); end
      step();
      nCmp++; if (rf_we !== 1'b0) begin nErr++; $display("FAIL same_end_we got=%b exp=0", rf_we); end
   endtask
`else
   task automatic test_long;
      drive(1'b1, 32'h1, 32'hFFFF_FFFF, 4'b0000, 4'd2, 4'd7, 1'b1, 1'b1, 1'b0);
      nCmp++; if (in_ready !== 1'b1) begin nErr++; $display("FAIL long_ready0 got=%b exp=1", in_ready); end
      step();
      in_valid = 1'b0;
      wrExp = {1'b1, 4'd2, 32'h1};
      nCmp++; if ({rf_we, rf_wa, rf_wd} !== wrExp) begin nErr++; $display("FAIL long_res got=%h exp=%h", {rf_we, rf_wa, rf_wd}, wrExp); end
      nCmp++; if (in_ready !== 1'b1) begin nErr++; $display("FAIL long_ready1 got=%b exp=1", in_ready); end
      step();
      wrExp = {1'b0, 4'd2, 32'h1};
      nCmp++; if ({rf_we, rf_wa, rf_wd} !== wrExp) begin nErr++; $display("FAIL long_noaux got=%h exp=%h", {rf_we, rf_wa, rf_wd}, wrExp); end
      nCmp++; if (busy !== 1'b0) begin nErr++; $display("FAIL long_busy got=%b exp=0", busy); end
   endtask
`endif

   task automatic test_reset_mid;
      drive(1'b1, 32'h66, 32'h88, 4'b1111, 4'd6, 4'd8, 1'b1, 1'b1, 1'b1);
      step();
      in_valid = 1'b0;
      nCmp++; if (flags_q !== 4'b1111) begin nErr++; $display("FAIL mid_flags_pre got=%b exp=1111", flags_q); end
`ifdef WB_LONG_WRITE_EN
      step();
      wrExp = {1'b1, 4'd8, 32'h88};
      nCmp++; if ({rf_we, rf_wa, rf_wd} !== wrExp) begin nErr++; $display("FAIL mid_aux got=%h exp=%h", {rf_we, rf_wa, rf_wd}, wrExp); end
`endif
      reset = 1'b0;
      #1;
      wrExp = '0;
      nCmp++; if ({rf_we, rf_wa, rf_wd} !== wrExp) begin nErr++; $display("FAIL mid_wr got=%h exp=%h", {rf_we, rf_wa, rf_wd}, wrExp); end
      nCmp++; if (flags_q !== 4'b0000) begin nErr++; $display("FAIL mid_flags got=%b exp=0000", flags_q); end
      nCmp++; if (busy !== 1'b0) begin nErr++; $display("FAIL mid_busy got=%b exp=0", busy); end
      #1;
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         nCmp++; if ({rf_we, busy} !== 2'b00) begin nErr++; $display("FAIL mid_after%0d got=%b exp=00", i, {rf_we, busy}); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_flags_only();
      test_back_to_back();
      test_long();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule
